cram_seq: RTL and testbench
===========================

Name: cram_seq

Overview:
- Macro-instruction sequencer that sits directly upstream of the compute-RAM array and drives its inst_i/we_i/addr_i/data_i ports.
- Accepts multi-bit vector commands (AND/OR/XOR/ADD/CPY/INV on N-bit fields stored column-wise) and expands each into a stream of bit-serial array instructions, one per cycle.
- Arbitrates host SRAM-mode read/write accesses onto the same port without corrupting in-flight instructions.

Parameters:
- COL, 256, array columns; column address width is 8.
- WORD_SIZE, 32, host data width and maximum field width.
- ADDR_W, 10, host word address width (128x256/32 words).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  macro command valid
- cmd_ready_o  out  1  macro command accept
- cmd_op_i  in  3  0 AND, 1 OR, 2 XOR, 3 ADD, 4 CPY, 5 INV, 6 ADDC (add, carry kept), 7 NOP
- cmd_a_i  in  8  base column of operand A (MSB column)
- cmd_b_i  in  8  base column of operand B
- cmd_d_i  in  8  base column of destination
- cmd_width_i  in  6  field width in bits, 1..32
- cmd_tag_i  in  1  set tag-enable bit on emitted data ops
- done_o  out  1  one-cycle pulse at macro completion
- busy_o  out  1  macro in progress
- host_req_i  in  1  host access request
- host_we_i  in  1  1 write, 0 read
- host_addr_i  in  ADDR_W  host word address
- host_wdata_i  in  WORD_SIZE  host write data
- host_gnt_o  out  1  host request accepted (combinational)
- host_rvalid_o  out  1  read data valid pulse
- host_rdata_o  out  WORD_SIZE  read data
- inst_o  out  32  to array inst_i: [31:28] enable (bit3 valid, bit0 tag), [27:24] opcode, [23:16] a, [15:8] b, [7:0] d
- we_o  out  1  to array we_i
- addr_o  out  ADDR_W  to array addr_i
- wdata_o  out  WORD_SIZE  to array data_i
- rdata_i  in  WORD_SIZE  from array data_o

Behaviour:
- Reset (async): state IDLE. inst_o, we_o, addr_o, wdata_o, host_rdata_o = 0. done_o, busy_o, host_rvalid_o, cmd_ready_o = 0.
- All array-side outputs are registered.
- Array opcodes used: AND 0, OR 1, XOR 2, ADD 6, CPY 7, INV 8, STC 11, CC 14.
- Emitted data ops carry enable = {1, 0, 0, cmd_tag}.
- Idle cycles drive inst_o = 0.
- FSM states: IDLE, PRE, RUN, DRAIN.
- IDLE:
  - cmd_ready_o = !host_req_i; host has priority.
  - host_gnt_o = host_req_i; host_gnt_o is 0 in every other state.
  - Command handshake (valid & ready) latches the command. ADD -> PRE; op 0-2, 4-6 -> RUN with k = 0; NOP or width 0 -> DRAIN.
- PRE: next-cycle inst_o = CC; then RUN.
- RUN: next-cycle inst_o = bit-k op with columns a/b/d = base + (width-1-k), mod 256.
  - Traversal is LSB first.
  - CPY and INV use b = 0.
  - After k = width-1, go to DRAIN.
- DRAIN: next-cycle inst_o = 0; done_o pulses in the DRAIN cycle; then IDLE.
- busy_o = state != IDLE.
- Instruction counts (inst_o enabled cycles):
  - Op 0-2, 4, 5, 6: width.
  - ADD: width + 1.
- Rationale for DRAIN: the array gates its registered instruction with the live we_i. DRAIN guarantees we_o is never high in the cycle after an enabled inst_o.
- Host write granted at cycle t: during t+1, we_o = 1, addr_o = host_addr_i, wdata_o = host_wdata_i, inst_o = 0.
- Host read granted at cycle t: addr_o set at t+1, we_o = 0. At t+2, rdata_i is registered into host_rdata_o and host_rvalid_o pulses. Read latency is 2.
- A host read may be granted back-to-back with the previous one; at most one read is outstanding per cycle.
- Simultaneous cmd_valid_i and host_req_i in IDLE: host is granted; the command waits, with its inputs held stable while valid.
- Reset mid-macro: abort immediately. No done_o; the emitted stream is truncated.

Optional Feature:
- Macro: CRAM_SEQ_CARRY_OUT_EN.
- Defined: for ADD and ADDC, after the last bit op an extra STC is emitted with d = (cmd_d_i - 1) mod 256, before DRAIN. Counts become width+2 (ADD) and width+1 (ADDC).
- Undefined: no STC; the carry stays only in the array carry latch.

Test Plan:
- ADD a=0, b=8, d=16, width=8, no tag -> inst_o sequence 0x8E000000, then 0x86070F17, 0x86060E16 ... 0x86000810; done_o in the following cycle; a host write of 8-bit values 200 and 100 read back as 44.
- XOR a=32, b=40, d=48, width=4, tag=1 -> four inst_o 0x92232B33, 0x92222A32, 0x92212931, 0x92202830; then idle, done_o pulse.
- host_req_i and cmd_valid_i raised together in IDLE -> host_gnt_o=1, cmd_ready_o=0, we_o=1 next cycle with inst_o=0; command accepted the following cycle.
- Host write addr=5, data=0xDEADBEEF, then read addr=5 -> host_rvalid_o two cycles after the read grant with host_rdata_o=0xDEADBEEF.
- CPY a=250, d=0, width=8 -> columns wrap: first op a=1 (257 mod 256), last op a=250; width=0 -> no enabled inst_o, done_o after 1 cycle.
- rst_ni pulled low during RUN at k=3 of width=16 -> all outputs 0 asynchronously, no done_o, cmd_ready_o=1 after release.

Source files
------------

// File: rtl/cram_seq.sv
// cram_seq: macro-instruction sequencer feeding the compute-RAM array port.
// Expands vector commands (AND/OR/XOR/ADD/CPY/INV/ADDC) into bit-serial array
// instructions, LSB first, one per cycle. Host SRAM-mode reads and writes share
// the same port and are granted only while the sequencer is idle.
// Optional feature macro: CRAM_SEQ_CARRY_OUT_EN. When defined, ADD/ADDC append
// an STC op that stores the final carry in column (cmd_d_i - 1).
module cram_seq #(
  parameter int COL       = 256,
  parameter int WORD_SIZE = 32,
  parameter int ADDR_W    = 10,
  localparam int CW       = $clog2(COL)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [2:0]           cmd_op_i,
  input  logic [CW-1:0]        cmd_a_i,
  input  logic [CW-1:0]        cmd_b_i,
  input  logic [CW-1:0]        cmd_d_i,
  input  logic [5:0]           cmd_width_i,
  input  logic                 cmd_tag_i,
  output logic                 done_o,
  output logic                 busy_o,
  input  logic                 host_req_i,
  input  logic                 host_we_i,
  input  logic [ADDR_W-1:0]    host_addr_i,
  input  logic [WORD_SIZE-1:0] host_wdata_i,
  output logic                 host_gnt_o,
  output logic                 host_rvalid_o,
  output logic [WORD_SIZE-1:0] host_rdata_o,
  output logic [31:0]          inst_o,
  output logic                 we_o,
  output logic [ADDR_W-1:0]    addr_o,
  output logic [WORD_SIZE-1:0] wdata_o,
  input  logic [WORD_SIZE-1:0] rdata_i
);

  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_CPY = 3'd4;
  localparam logic [2:0] OP_INV = 3'd5;
  localparam logic [2:0] OP_NOP = 3'd7;

  localparam logic [3:0] OPC_AND = 4'd0;
  localparam logic [3:0] OPC_OR  = 4'd1;
  localparam logic [3:0] OPC_XOR = 4'd2;
  localparam logic [3:0] OPC_ADD = 4'd6;
  localparam logic [3:0] OPC_CPY = 4'd7;
  localparam logic [3:0] OPC_INV = 4'd8;
  localparam logic [3:0] OPC_STC = 4'd11;
  localparam logic [3:0] OPC_CC  = 4'd14;

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_RUN, ST_DRAIN} state_e;

  state_e               state_r, state_nxt_s;
  logic [5:0]           k_r, k_nxt_s;
  logic [2:0]           op_r;
  logic [CW-1:0]        a_r, b_r, d_r;
  logic [5:0]           width_r;
  logic                 tag_r;
  logic                 live_r;
  logic                 rd_pend_r;
  logic                 idle_s, cmd_fire_s, last_bit_s, run_end_s, stc_step_s;
  logic [31:0]          inst_nxt_s;
  logic                 we_nxt_s, rd_issue_s;
  logic [ADDR_W-1:0]    addr_nxt_s;
  logic [WORD_SIZE-1:0] wdata_nxt_s;
  logic [CW-1:0]        b_col_s;

  // Column of bit k for a field whose MSB sits at base; k = 0 is the LSB.
  function automatic logic [CW-1:0] col_at(input logic [CW-1:0] base,
                                           input logic [5:0] width,
                                           input logic [5:0] k);
    logic [5:0] off;
    off = width - 6'd1 - k;
    return base + CW'(off);
  endfunction

  // Macro opcode to array opcode; ADDC uses the plain bit-add without the carry clear.
  function automatic logic [3:0] array_opc(input logic [2:0] op);
    logic [3:0] opc;
    case (op)
      3'd0:       opc = OPC_AND;
      3'd1:       opc = OPC_OR;
      3'd2:       opc = OPC_XOR;
      3'd3, 3'd6: opc = OPC_ADD;
      3'd4:       opc = OPC_CPY;
      3'd5:       opc = OPC_INV;
      default:    opc = 4'd0;
    endcase
    return opc;
  endfunction

  assign idle_s      = (state_r == ST_IDLE);
  assign host_gnt_o  = live_r & idle_s & host_req_i;
  assign cmd_ready_o = live_r & idle_s & ~host_req_i;
  assign cmd_fire_s  = cmd_valid_i & cmd_ready_o;
  assign busy_o      = ~idle_s;
  assign done_o      = (state_r == ST_DRAIN);
  assign last_bit_s  = (k_r == (width_r - 6'd1));
  assign b_col_s     = ((op_r == OP_CPY) || (op_r == OP_INV)) ? {CW{1'b0}}
                                                             : col_at(b_r, width_r, k_r);

`ifdef CRAM_SEQ_CARRY_OUT_EN
  logic is_add_s;
  assign is_add_s   = (op_r == OP_ADD) || (op_r == 3'd6);
  assign stc_step_s = is_add_s & (k_r == width_r);
  assign run_end_s  = is_add_s ? stc_step_s : last_bit_s;
`else
  assign stc_step_s = 1'b0;
  assign run_end_s  = last_bit_s;
`endif

  // Keeps the command/host handshakes closed until the first clock after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) live_r <= 1'b0;
    else         live_r <= 1'b1;
  end

  // State register and bit counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      k_r     <= 6'd0;
    end else begin
      state_r <= state_nxt_s;
      k_r     <= k_nxt_s;
    end
  end

  // Next-state logic: decode on accept, walk the bits, always drain once.
  always_comb begin
    state_nxt_s = state_r;
    k_nxt_s     = k_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_fire_s) begin
          k_nxt_s = 6'd0;
          if ((cmd_op_i == OP_NOP) || (cmd_width_i == 6'd0)) state_nxt_s = ST_DRAIN;
          else if (cmd_op_i == OP_ADD)                       state_nxt_s = ST_PRE;
          else                                               state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRE:   state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (run_end_s) state_nxt_s = ST_DRAIN;
        else           k_nxt_s     = k_r + 6'd1;
      end
      ST_DRAIN: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered array-side outputs.
  always_comb begin
    inst_nxt_s  = 32'd0;
    we_nxt_s    = 1'b0;
    rd_issue_s  = 1'b0;
    addr_nxt_s  = addr_o;
    wdata_nxt_s = wdata_o;
    case (state_r)
      ST_IDLE: begin
        if (host_gnt_o) begin
          addr_nxt_s = host_addr_i;
          if (host_we_i) begin
            we_nxt_s    = 1'b1;
            wdata_nxt_s = host_wdata_i;
          end else begin
            rd_issue_s = 1'b1;
          end
        end else begin
          inst_nxt_s = 32'd0;
        end
      end
      ST_PRE: inst_nxt_s = {4'b1000, OPC_CC, 24'd0};
      ST_RUN: begin
        if (stc_step_s) begin
          inst_nxt_s = {4'b1000, OPC_STC, {CW{1'b0}}, {CW{1'b0}}, d_r - {{(CW-1){1'b0}}, 1'b1}};
        end else begin
          inst_nxt_s = {1'b1, 2'b00, tag_r, array_opc(op_r), col_at(a_r, width_r, k_r),
                        b_col_s, col_at(d_r, width_r, k_r)};
        end
      end
      ST_DRAIN: inst_nxt_s = 32'd0;
      default:  inst_nxt_s = 32'd0;
    endcase
  end

  // Array-side output registers and the two-stage host read return path.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inst_o        <= 32'd0;
      we_o          <= 1'b0;
      addr_o        <= {ADDR_W{1'b0}};
      wdata_o       <= {WORD_SIZE{1'b0}};
      rd_pend_r     <= 1'b0;
      host_rvalid_o <= 1'b0;
      host_rdata_o  <= {WORD_SIZE{1'b0}};
    end else begin
      inst_o        <= inst_nxt_s;
      we_o          <= we_nxt_s;
      addr_o        <= addr_nxt_s;
      wdata_o       <= wdata_nxt_s;
      rd_pend_r     <= rd_issue_s;
      host_rvalid_o <= rd_pend_r;
      if (rd_pend_r) host_rdata_o <= rdata_i;
    end
  end

  // Command fields captured on accept and held for the whole macro.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_r    <= 3'd0;
      a_r     <= {CW{1'b0}};
      b_r     <= {CW{1'b0}};
      d_r     <= {CW{1'b0}};
      width_r <= 6'd0;
      tag_r   <= 1'b0;
    end else if (cmd_fire_s) begin
      op_r    <= cmd_op_i;
      a_r     <= cmd_a_i;
      b_r     <= cmd_b_i;
      d_r     <= cmd_d_i;
      width_r <= cmd_width_i;
      tag_r   <= cmd_tag_i;
    end
  end

endmodule

// File: tb/tb_cram_seq.sv
// tb_cram_seq: randomized and directed checks of cram_seq against a
// behavioural model of the expected instruction stream and host memory.
module tb_cram_seq;
  localparam int ADDR_W    = 10;
  localparam int WORD_SIZE = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic cmd_valid, cmd_ready, cmd_tag, done, busy;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a, cmd_b, cmd_d;
  logic [5:0] cmd_width;
  logic host_req, host_we, host_gnt, host_rvalid;
  logic [ADDR_W-1:0] host_addr, addr_o;
  logic [WORD_SIZE-1:0] host_wdata, host_rdata, wdata_o, arr_rdata;
  logic [31:0] inst_o;
  logic we_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  cram_seq #(.COL(256), .WORD_SIZE(WORD_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_d_i(cmd_d), .cmd_width_i(cmd_width),
    .cmd_tag_i(cmd_tag), .done_o(done), .busy_o(busy),
    .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_wdata_i(host_wdata), .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid),
    .host_rdata_o(host_rdata), .inst_o(inst_o), .we_o(we_o), .addr_o(addr_o),
    .wdata_o(wdata_o), .rdata_i(arr_rdata)
  );

  // Simple SRAM-mode view of the array: combinational read, clocked write.
  logic [WORD_SIZE-1:0] arr_mem [0:1023];
  assign arr_rdata = arr_mem[addr_o];
  always @(posedge clk) if (we_o) arr_mem[addr_o] <= wdata_o;

  // Reference model state.
  logic [31:0] ref_mem [int];
  int          wr_addrs [$];
  logic [31:0] exp_q [$];
  int unsigned opc_tbl [8] = '{0, 1, 2, 6, 7, 8, 6, 0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected enabled instructions of one macro, derived from the command rules.
  function automatic void build_exp(input int op, input int a, input int b,
                                    input int d, input int w, input int tag);
    exp_q.delete();
    if (op == 7 || w == 0) return;
    if (op == 3) exp_q.push_back(32'h8E00_0000);
    for (int i = 0; i < w; i++) begin
      int unsigned off, ac, bc, dc, word;
      off  = w - 1 - i;
      ac   = (a + off) % 256;
      bc   = (op == 4 || op == 5) ? 0 : (b + off) % 256;
      dc   = (d + off) % 256;
      word = ((8 + tag) << 28) | (opc_tbl[op] << 24) | (ac << 16) | (bc << 8) | dc;
      exp_q.push_back(word);
    end
`ifdef CRAM_SEQ_CARRY_OUT_EN
    if (op == 3 || op == 6) exp_q.push_back((32'd8 << 28) | (32'd11 << 24) | ((d + 255) % 256));
`endif
  endfunction

  task automatic host_write(input logic [9:0] addr, input logic [31:0] data);
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = addr; host_wdata = data;
    #1;
    check("wr_gnt", host_gnt, 1'b1);
    @(posedge clk); @(negedge clk);
    check("wr_we", we_o, 1'b1);
    check("wr_addr", addr_o, addr);
    check("wr_data", wdata_o, data);
    check("wr_inst", inst_o, 32'd0);
    host_req = 1'b0; host_we = 1'b0;
    ref_mem[int'(addr)] = data;
    wr_addrs.push_back(int'(addr));
  endtask

  task automatic host_read2(input logic [9:0] a1, input logic [9:0] a2, input bit two);
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = a1;
    #1;
    check("rd_gnt", host_gnt, 1'b1);
    @(posedge clk); @(negedge clk);
    check("rd_addr", addr_o, a1);
    check("rd_we", we_o, 1'b0);
    check("rd_early", host_rvalid, 1'b0);
    if (two) begin
      host_addr = a2;
      #1;
      check("rd_gnt2", host_gnt, 1'b1);
    end else begin
      host_req = 1'b0;
    end
    @(posedge clk); @(negedge clk);
    check("rd_valid", host_rvalid, 1'b1);
    check("rd_data", host_rdata, ref_mem[int'(a1)]);
    host_req = 1'b0;
    if (two) begin
      check("rd_addr2", addr_o, a2);
      @(posedge clk); @(negedge clk);
      check("rd_valid2", host_rvalid, 1'b1);
      check("rd_data2", host_rdata, ref_mem[int'(a2)]);
    end
    @(posedge clk); @(negedge clk);
    check("rd_pulse", host_rvalid, 1'b0);
  endtask

  // Issue one macro and check every cycle until it is back in idle.
  task automatic run_cmd(input int op, input int a, input int b, input int d,
                         input int w, input int tag, input bit with_host, input bit do_rst);
    int n, waitc;
    logic [31:0] e;
    build_exp(op, a, b, d, w, tag);
    n = exp_q.size();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op[2:0]; cmd_a = a[7:0]; cmd_b = b[7:0];
    cmd_d = d[7:0]; cmd_width = w[5:0]; cmd_tag = tag[0];
    if (with_host) begin
      host_req = 1'b1; host_we = 1'b1; host_addr = 10'd7; host_wdata = 32'h1234_5678;
      #1;
      check("both_gnt", host_gnt, 1'b1);
      check("both_ready", cmd_ready, 1'b0);
      @(posedge clk); @(negedge clk);
      check("both_we", we_o, 1'b1);
      check("both_inst", inst_o, 32'd0);
      check("both_wdata", wdata_o, 32'h1234_5678);
      host_req = 1'b0; host_we = 1'b0;
      ref_mem[7] = 32'h1234_5678;
      wr_addrs.push_back(7);
    end
    #1;
    waitc = 0;
    while (!cmd_ready && waitc < 20) begin
      @(negedge clk); #1; waitc++;
    end
    check("cmd_ready", cmd_ready, 1'b1);
    check("idle_busy", busy, 1'b0);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 1; c <= n + 2; c++) begin
      e = (c >= 2 && c <= n + 1) ? exp_q[c-2] : 32'd0;
      check("inst", inst_o, e);
      check("done", done, (c == n + 1));
      check("busy", busy, (c <= n + 1));
      check("we_quiet", we_o, 1'b0);
      if (do_rst && c == 4) begin
        rst_n = 1'b0;
        #1;
        check("rst_inst", inst_o, 32'd0);
        check("rst_we", we_o, 1'b0);
        check("rst_addr", addr_o, 10'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ready", cmd_ready, 1'b0);
        check("rst_rvalid", host_rvalid, 1'b0);
        check("rst_rdata", host_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check("post_rst_done", done, 1'b0);
          check("post_rst_inst", inst_o, 32'd0);
          check("post_rst_ready", cmd_ready, 1'b1);
        end
        break;
      end
      if (c < n + 2) @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = 8'd0; cmd_b = 8'd0;
    cmd_d = 8'd0; cmd_width = 6'd0; cmd_tag = 1'b0; host_req = 1'b0; host_we = 1'b0;
    host_addr = 10'd0; host_wdata = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_inst", inst_o, 32'd0);
    check("reset_we", we_o, 1'b0);
    check("reset_addr", addr_o, 10'd0);
    check("reset_wdata", wdata_o, 32'd0);
    check("reset_rdata", host_rdata, 32'd0);
    check("reset_done", done, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_rvalid", host_rvalid, 1'b0);
    check("reset_ready", cmd_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1'b1);

    // Directed cases.
    run_cmd(3, 0, 8, 16, 8, 0, 1'b0, 1'b0);       // ADD with carry clear
    run_cmd(2, 32, 40, 48, 4, 1, 1'b0, 1'b0);     // XOR, tagged
    host_write(10'd5, 32'hDEAD_BEEF);
    host_read2(10'd5, 10'd5, 1'b0);
    run_cmd(0, 1, 2, 3, 5, 0, 1'b1, 1'b0);        // host and command together
    run_cmd(4, 250, 99, 0, 8, 0, 1'b0, 1'b0);     // CPY with column wrap
    run_cmd(1, 10, 20, 30, 0, 1, 1'b0, 1'b0);     // width 0
    run_cmd(7, 10, 20, 30, 5, 0, 1'b0, 1'b0);     // NOP
    run_cmd(6, 200, 100, 0, 32, 1, 1'b0, 1'b0);   // ADDC full width, d wraps below 0
    run_cmd(5, 255, 7, 128, 1, 0, 1'b0, 1'b0);    // INV single bit
    host_read2(10'd5, 10'd7, 1'b1);               // back-to-back reads
    run_cmd(0, 10, 20, 30, 16, 0, 1'b0, 1'b1);    // reset in the middle of RUN
    host_read2(10'd7, 10'd5, 1'b1);

    // Randomized mix of macros and host traffic.
    for (int it = 0; it < 60; it++) begin
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0) begin
        host_write(10'($urandom_range(0, 1023)), $urandom);
      end else if (sel == 1 && wr_addrs.size() > 0) begin
        host_read2(10'(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)]),
                   10'(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)]),
                   1'($urandom_range(0, 1)));
      end else begin
        run_cmd($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 32), $urandom_range(0, 1),
                1'b0, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
